// File: rtl/cksum_engine_pkg.sv
// Shared definitions for the one's-complement checksum engine: mode codes,
// FSM states and a 16-bit end-around-carry adder.
package cksum_engine_pkg;

  localparam logic [1:0]  CK_MODE_GEN    = 2'b00;
  localparam logic [1:0]  CK_MODE_VERIFY = 2'b01;
  localparam logic [1:0]  CK_MODE_UPDATE = 2'b10;
  localparam logic [15:0] ZERO_HALF      = 16'h0000;

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_READ, S_DRAIN, S_FOLD, S_STORE, S_DONE, S_RD_OLD, S_UPD
  } state_e;

  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/cksum_lane_add.sv
// Sums the 16-bit lanes of one memory word, keeping only bytes inside [lo, hi).
// Lane 0 sits in the MSBs (lowest address); a trailing odd byte pads with zero.
module cksum_lane_add #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int SUM_W  = 18
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W:0]   lo_i,
  input  logic [ADDR_W:0]   hi_i,
  output logic [SUM_W-1:0]  sum_o
);
  localparam int LANES = DATA_W/16;

  logic [LANES-1:0][1:0]  mask_w;
  logic [LANES-1:0][15:0] lane_w;

  genvar k;
  for (k = 0; k < LANES; k++) begin : g_lane
    logic [ADDR_W:0] a0;
    assign a0        = {1'b0, addr_i} + (ADDR_W+1)'(2*k);
    assign mask_w[k] = {(a0 >= lo_i) && (a0 < hi_i),
                        (a0 >= lo_i) && ((a0 + (ADDR_W+1)'(1)) < hi_i)};
    assign lane_w[k] = {word_i[DATA_W-1-16*k -: 8] & {8{mask_w[k][1]}},
                        word_i[DATA_W-9-16*k -: 8] & {8{mask_w[k][0]}}};
  end

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < LANES; i++) sum_o = sum_o + SUM_W'(lane_w[i]);
  end

endmodule

// File: rtl/cksum_engine.sv
// RFC 1071 checksum engine on the shared packet SRAM port: GEN writes the
// checksum, VERIFY only reports, UPDATE patches an existing checksum (RFC 1624).
module cksum_engine
  import cksum_engine_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [ADDR_W-1:0] field_start_i,
  input  logic [LEN_W-1:0]  field_len_i,
  input  logic [ADDR_W-1:0] dst_field_i,
  input  logic [15:0]       old_val_i,
  input  logic [15:0]       new_val_i,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_width_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [15:0]       result_o,
  output logic              ok_o,
  output logic              err_o,
  output logic              ready_o
);
  localparam int BYTES = DATA_W/8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int ACC_W = 17 + LEN_W - 1;
  localparam int SUM_W = 16 + $clog2(DATA_W/16);
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(BYTES-1);

  state_e            state_q;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] start_q, last_q, dst_q, raddr_q, addr_q;
  logic [ADDR_W:0]   end_q;
  logic              len_zero_q, rvalid_q;
  logic [15:0]       old_q, new_q, result_q;
  logic [ACC_W-1:0]  acc_q;
  logic              ce_q, we_q, ok_q, err_q, ready_q;
  logic [3:0]        width_q;
  logic [DATA_W-1:0] wdata_q;

  logic [ADDR_W:0]   end_d;
  logic [ADDR_W-1:0] last_d;
  logic              err_d, fold_done;
  logic [SUM_W-1:0]  lane_sum;
  logic [ACC_W-1:0]  fold_d;
  logic [15:0]       cks_d, upd_d;
  logic [DATA_W-1:0] hc_sh;

  assign end_d     = {1'b0, field_start_i} + (ADDR_W+1)'(field_len_i);
  assign last_d    = (end_d[ADDR_W-1:0] - ADDR_W'(1)) & ALIGN;
  assign err_d     = (mode_i == 2'b11) || field_start_i[0] || dst_field_i[0];
  assign fold_d    = ACC_W'(acc_q[ACC_W-1:16]) + ACC_W'(acc_q[15:0]);
  assign fold_done = (acc_q[ACC_W-1:16] == '0);
  assign cks_d     = ~acc_q[15:0];
  // The old checksum lives in the lane selected by dst's offset inside the word.
  assign hc_sh     = mem_data_i << {dst_q[OFF_W-1:1], 4'b0000};
  assign upd_d     = ~ones_add(ones_add(~hc_sh[DATA_W-1 -: 16], ~old_q), new_q);

  cksum_lane_add #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SUM_W(SUM_W)) u_lane_add (
    .word_i (mem_data_i),
    .addr_i (raddr_q),
    .lo_i   ({1'b0, start_q}),
    .hi_i   (end_q),
    .sum_o  (lane_sum)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;   mode_q <= '0;    start_q <= '0;  last_q <= '0;
      dst_q <= '0;         raddr_q <= '0;   addr_q <= '0;   end_q <= '0;
      len_zero_q <= 1'b0;  rvalid_q <= 1'b0; old_q <= '0;   new_q <= '0;
      result_q <= '0;      acc_q <= '0;     ce_q <= 1'b0;   we_q <= 1'b0;
      ok_q <= 1'b0;        err_q <= 1'b0;   ready_q <= 1'b0;
      width_q <= '0;       wdata_q <= '0;
    end else begin
      // Read data returns one cycle after its address; fold it in on arrival.
      if (rvalid_q) acc_q <= acc_q + ACC_W'(lane_sum);
      rvalid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start_i) begin
          mode_q <= mode_i;  start_q <= field_start_i;  end_q <= end_d;  last_q <= last_d;
          dst_q <= dst_field_i;  old_q <= old_val_i;  new_q <= new_val_i;
          len_zero_q <= (field_len_i == '0);
          acc_q <= '0;  result_q <= '0;  ok_q <= 1'b0;  err_q <= 1'b0;
          if (err_d) begin
            err_q <= 1'b1;  ready_q <= 1'b1;  state_q <= S_DONE;
          end else if (mode_i == CK_MODE_GEN) begin
            state_q <= S_CLEAR;  ce_q <= 1'b1;  we_q <= 1'b1;
            addr_q <= dst_field_i;  width_q <= 4'd2;  wdata_q <= DATA_W'(ZERO_HALF);
          end else if (mode_i == CK_MODE_VERIFY) begin
            if (field_len_i == '0) state_q <= S_FOLD;
            else begin
              state_q <= S_READ;  ce_q <= 1'b1;
              addr_q <= field_start_i & ALIGN;  width_q <= 4'(BYTES);
            end
          end else begin
            state_q <= S_RD_OLD;  ce_q <= 1'b1;
            addr_q <= dst_field_i & ALIGN;  width_q <= 4'(BYTES);
          end
        end
        S_CLEAR: begin
          we_q <= 1'b0;  wdata_q <= '0;
          if (len_zero_q) begin
            state_q <= S_FOLD;  ce_q <= 1'b0;  addr_q <= '0;  width_q <= '0;
          end else begin
            state_q <= S_READ;  addr_q <= start_q & ALIGN;  width_q <= 4'(BYTES);
          end
        end
        S_READ: begin
          rvalid_q <= 1'b1;
          raddr_q  <= addr_q;
          if (addr_q == last_q) begin
            state_q <= S_DRAIN;  ce_q <= 1'b0;  addr_q <= '0;  width_q <= '0;
          end else addr_q <= addr_q + ADDR_W'(BYTES);
        end
        S_DRAIN: state_q <= S_FOLD;
        S_FOLD: begin
          if (!fold_done) acc_q <= fold_d;
          else if (mode_q == CK_MODE_GEN) begin
            result_q <= cks_d;  state_q <= S_STORE;  ce_q <= 1'b1;  we_q <= 1'b1;
            addr_q <= dst_q;  width_q <= 4'd2;  wdata_q <= DATA_W'(cks_d);
          end else begin
            result_q <= acc_q[15:0];  ok_q <= (acc_q[15:0] == 16'hFFFF);
            ready_q <= 1'b1;  state_q <= S_DONE;
          end
        end
        S_RD_OLD: begin
          state_q <= S_UPD;  ce_q <= 1'b0;  addr_q <= '0;  width_q <= '0;
        end
        S_UPD: begin
          result_q <= upd_d;  state_q <= S_STORE;  ce_q <= 1'b1;  we_q <= 1'b1;
          addr_q <= dst_q;  width_q <= 4'd2;  wdata_q <= DATA_W'(upd_d);
        end
        S_STORE: begin
          ce_q <= 1'b0;  we_q <= 1'b0;  addr_q <= '0;  width_q <= '0;  wdata_q <= '0;
          ready_q <= 1'b1;  state_q <= S_DONE;
        end
        S_DONE: if (!start_i) begin
          ready_q <= 1'b0;  state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_ce_o    = ce_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_width_o = width_q;
  assign mem_data_o  = wdata_q;
  assign result_o    = result_q;
  assign ok_o        = ok_q;
  assign err_o       = err_q;
  assign ready_o     = ready_q;

endmodule

// File: tb/tb_cksum_engine.sv
// Scoreboard bench for cksum_engine: byte-level SRAM model, per-byte checksum
// reference, directed RFC examples plus randomized operations.
module tb_cksum_engine;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int NB = DW/8;
  localparam int TMO = 2000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] fstart = '0, dst = '0;
  logic [LW-1:0] flen = '0;
  logic [15:0]   oldv = '0, newv = '0;
  logic          mem_ce_o, mem_we_o, ok_o, err_o, ready_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_width_o;
  logic [DW-1:0] mem_data_o;
  logic [DW-1:0] rdata = '0;
  logic [15:0]   result_o;

  cksum_engine #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start_i(start), .mode_i(mode),
    .field_start_i(fstart), .field_len_i(flen), .dst_field_i(dst),
    .old_val_i(oldv), .new_val_i(newv),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_width_o(mem_width_o), .mem_data_o(mem_data_o), .mem_data_i(rdata),
    .result_o(result_o), .ok_o(ok_o), .err_o(err_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        ok;
    logic        err;
    int          wr;
    logic [15:0] dval;
    logic [11:0] dst;
    bit          chk_mem;
    bit          no_ce;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] wlog[$];
  logic [7:0]  mem [0:4095];
  int          checks = 0, errors = 0;
  int          wr_cnt = 0, ce_cnt = 0, wr_base = 0, ce_base = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // SRAM: 16-bit big-endian writes, word reads returned one cycle later, junk otherwise.
  always @(posedge clk) begin : mem_p
    logic [DW-1:0] w;
    if (mem_ce_o) ce_cnt++;
    if (mem_ce_o && mem_we_o) begin
      mem[mem_addr_o[11:0]]         = mem_data_o[15:8];
      mem[mem_addr_o[11:0] + 12'd1] = mem_data_o[7:0];
      wr_cnt++;
      wlog.push_back(mem_data_o[15:0]);
    end
    w = DW'({$urandom, $urandom});
    if (mem_ce_o && !mem_we_o)
      for (int b = 0; b < NB; b++) w[DW-1-8*b -: 8] = mem[mem_addr_o[11:0] + 12'(b)];
    rdata <= w;
  end

  function automatic logic [15:0] fold16(input logic [31:0] s);
    while (s[31:16] != 16'd0) s = {16'd0, s[31:16]} + {16'd0, s[15:0]};
    return s[15:0];
  endfunction

  function automatic logic [31:0] region_sum(input int st, input int len, input int d, input bit zdst);
    logic [31:0] s = 0;
    for (int i = 0; i < len; i++) begin
      int a = st + i;
      logic [7:0] b = mem[a[11:0]];
      if (zdst && (a == d || a == d + 1)) b = 8'h00;
      s += (i % 2 == 0) ? {16'd0, b, 8'h00} : {24'd0, b};
    end
    return s;
  endfunction

  task automatic run_op(input logic [1:0] m, input int st, input int len, input int d,
                        input logic [15:0] ov, input logic [15:0] nv,
                        output logic [15:0] res, output logic ok);
    exp_t e;
    logic [15:0] f, hc;
    int n;
    e = '{res: 16'h0, ok: 1'b0, err: 1'b0, wr: 0, dval: 16'h0, dst: d[11:0], chk_mem: 1'b0, no_ce: 1'b0};
    if (m == 2'b11 || st[0] || d[0]) begin
      e.err = 1'b1;  e.no_ce = 1'b1;
    end else if (m == 2'b00) begin
      f = fold16(region_sum(st, len, d, 1'b1));
      e.res = ~f;  e.wr = 2;  e.dval = ~f;  e.chk_mem = 1'b1;
    end else if (m == 2'b01) begin
      f = fold16(region_sum(st, len, d, 1'b0));
      e.res = f;  e.ok = (f == 16'hFFFF);  e.dval = {mem[d[11:0]], mem[d[11:0] + 12'd1]};  e.chk_mem = 1'b1;
    end else begin
      hc = {mem[d[11:0]], mem[d[11:0] + 12'd1]};
      f = fold16({16'd0, ~hc} + {16'd0, ~ov} + {16'd0, nv});
      e.res = ~f;  e.wr = 1;  e.dval = ~f;  e.chk_mem = 1'b1;
    end
    sb.push_back(e);
    wr_base = wr_cnt;  ce_base = ce_cnt;  wlog.delete();
    mode = m;  fstart = AW'(st);  flen = LW'(len);  dst = AW'(d);  oldv = ov;  newv = nv;
    start = 1'b1;
    n = 0;
    while (!ready_o && n < TMO) begin @(negedge clk); n++; end
    if (!ready_o) begin
      check("ready_timeout", {31'd0, ready_o}, 32'd1);
      if (sb.size() > 0) void'(sb.pop_back());
    end
    res = result_o;  ok = ok_o;
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compare on every rising ready_o, independent of the stimulus.
  initial begin : monitor
    logic rdy_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (ready_o && !rdy_prev) begin
        if (sb.size() == 0) check("spurious_ready", {31'd0, ready_o}, 32'd0);
        else begin
          e = sb.pop_front();
          check("result", {16'd0, result_o}, {16'd0, e.res});
          check("ok", {31'd0, ok_o}, {31'd0, e.ok});
          check("err", {31'd0, err_o}, {31'd0, e.err});
          check("write_count", wr_cnt - wr_base, e.wr);
          if (e.no_ce) check("ce_on_error", ce_cnt - ce_base, 0);
          if (e.chk_mem) check("dst_mem", {16'd0, mem[e.dst], mem[e.dst + 12'd1]}, {16'd0, e.dval});
        end
      end
      rdy_prev = ready_o;
    end
  end

  logic [15:0] r;
  logic        k;
  logic [7:0]  hdr [0:19];

  initial begin
    hdr = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
            8'h12, 8'h34, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7};
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    #2 rst = 1'b0;
    #1;
    check("rst_ctl", {27'd0, mem_ce_o, mem_we_o, ready_o, ok_o, err_o}, 32'd0);
    check("rst_result", {16'd0, result_o}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 20; i++) mem[12'h100 + 12'(i)] = hdr[i];
    run_op(2'b00, 'h100, 20, 'h10A, 16'h0, 16'h0, r, k);
    check("ipv4_gen", {16'd0, r}, 32'h0000B861);
    check("ipv4_wr_n", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("ipv4_clear", {16'd0, wlog[0]}, 32'h0);
      check("ipv4_store", {16'd0, wlog[1]}, 32'h0000B861);
    end
    run_op(2'b01, 'h100, 20, 'h10A, 16'h0, 16'h0, r, k);
    check("ipv4_verify_ok", {15'd0, k, r}, 32'h0001FFFF);
    mem[12'h105] = 8'h01;
    run_op(2'b01, 'h100, 20, 'h10A, 16'h0, 16'h0, r, k);
    check("ipv4_corrupt_ok", {31'd0, k}, 32'd0);

    mem[12'h202] = 8'h01;  mem[12'h203] = 8'h02;  mem[12'h204] = 8'h03;
    run_op(2'b00, 'h202, 3, 'h300, 16'h0, 16'h0, r, k);
    check("odd_len_gen", {16'd0, r}, 32'h0000FBFD);

    mem[12'h400] = 8'hDD;  mem[12'h401] = 8'h2F;
    run_op(2'b10, 'h0, 0, 'h400, 16'h5555, 16'h3285, r, k);
    check("rfc1624_upd", {16'd0, mem[12'h400], mem[12'h401]}, 32'h0);

    run_op(2'b11, 'h100, 20, 'h10A, 16'h0, 16'h0, r, k);
    run_op(2'b00, 'h101, 20, 'h10A, 16'h0, 16'h0, r, k);
    run_op(2'b10, 'h100, 20, 'h10B, 16'h0, 16'h0, r, k);

    // Abort a long GEN in the middle of its reads.
    mode = 2'b00;  fstart = AW'(32'h500);  flen = LW'(64);  dst = AW'(32'hE00);
    start = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_rst_reading", {30'd0, mem_ce_o, mem_we_o}, 32'd2);
    rst = 1'b0;
    #1;
    check("abort_ctl", {27'd0, mem_ce_o, mem_we_o, ready_o, ok_o, err_o}, 32'd0);
    check("abort_addr", mem_addr_o, 32'd0);
    check("abort_data", {mem_data_o[DW-1:4], mem_width_o}, 32'd0);
    check("abort_result", {16'd0, result_o}, 32'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op(2'b00, 'h600, 0, 'h700, 16'h0, 16'h0, r, k);
    check("len0_gen", {16'd0, r}, 32'h0000FFFF);
    run_op(2'b00, 'h500, 64, 'hE00, 16'h0, 16'h0, r, k);

    for (int t = 0; t < 40; t++) begin
      logic [1:0] m;
      int st, d;
      m  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      st = 'h400 + 2 * $urandom_range(0, 'h300);
      if ($urandom_range(0, 11) == 0) st = st + 1;
      d  = 'h400 + 2 * $urandom_range(0, 'h580);
      run_op(m, st, $urandom_range(0, 80), d, 16'($urandom), 16'($urandom), r, k);
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
